mux41_arb: RTL

MUX41_ARB -- requirements
Module: mux41_arb

---
 rtl/mux41_arb.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mux41_arb.sv
// 4:1 round-robin arbitrated multiplexer with registered grant/select and a combinational data path.
// Optional per-owner hold timeout is compiled in with `define MUX41_ARB_TIMEOUT_EN.
module mux41_arb #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic [3:0] in3,
  input  logic [3:0] in4,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic [3:0] out,
  output logic       valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_reg;
  logic [1:0] ptr_reg;
  logic [1:0] sel_reg;
  logic [3:0] gnt_reg;
  logic       valid_reg;

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_max_range
    $error("mux41_arb: HOLD_MAX must be within 2..255");
  end

  // Candidate tables: entry gi is the requester examined gi-th in search order.
  logic [1:0] next_base;
  logic [3:0] other_req;
  logic [1:0] idle_cand [4];
  logic [1:0] rot_cand  [4];
  logic [3:0] idle_hits;
  logic [3:0] rot_hits;

  assign next_base = sel_reg + 2'd1;
  assign other_req = req & ~gnt_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_search
    assign idle_cand[gi] = ptr_reg + 2'(gi);
    assign rot_cand[gi]  = next_base + 2'(gi);
    assign idle_hits[gi] = req[idle_cand[gi]];
    assign rot_hits[gi]  = other_req[rot_cand[gi]];
  end

  logic       idle_hit;
  logic [1:0] idle_idx;
  logic       rot_hit;
  logic [1:0] rot_idx;

  always_comb begin
    idle_hit = |idle_hits;
    rot_hit  = |rot_hits;
    idle_idx = idle_cand[0];
    rot_idx  = rot_cand[0];
    for (int k = 3; k >= 0; k--) begin
      if (idle_hits[k]) idle_idx = idle_cand[k];
      if (rot_hits[k])  rot_idx  = rot_cand[k];
    end
  end

  logic hold_expired;
  logic owner_release;
  logic do_switch;

  assign owner_release = ~req[sel_reg];
  assign do_switch     = (state_reg == GRANT) && (owner_release || (hold_expired && rot_hit));

`ifdef MUX41_ARB_TIMEOUT_EN
  logic [7:0] hold_reg;

  assign hold_expired = (hold_reg == 8'(HOLD_MAX - 1));

  // Cleared while idle and on every hand-over, so each new owner starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg <= 8'd0;
    end else if (state_reg != GRANT || do_switch) begin
      hold_reg <= 8'd0;
    end else if (hold_expired) begin
      hold_reg <= 8'd0;
    end else begin
      hold_reg <= hold_reg + 8'd1;
    end
  end
`else
  assign hold_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= 2'd0;
      sel_reg   <= 2'd0;
      gnt_reg   <= 4'b0000;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (idle_hit) begin
            state_reg <= GRANT;
            sel_reg   <= idle_idx;
            gnt_reg   <= 4'b0001 << idle_idx;
            valid_reg <= 1'b1;
          end
        end
        GRANT: begin
          if (do_switch) begin
            ptr_reg <= next_base;
            if (rot_hit) begin
              // Hand over directly to the next requester without an idle bubble.
              sel_reg   <= rot_idx;
              gnt_reg   <= 4'b0001 << rot_idx;
              valid_reg <= 1'b1;
            end else begin
              state_reg <= IDLE;
              gnt_reg   <= 4'b0000;
              valid_reg <= 1'b0;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          gnt_reg   <= 4'b0000;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign gnt   = gnt_reg;
  assign sel   = sel_reg;
  assign valid = valid_reg;

  always_comb begin
    case (sel_reg)
      2'd0:    out = in1;
      2'd1:    out = in2;
      2'd2:    out = in3;
      default: out = in4;
    endcase
    out = out & {4{valid_reg}};
  end

endmodule
